// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// This module sequences the fetch datapath, which is an instruction memory
// plus a fetch stage.
//
// Boot load (only when FETCH_CTRL_BOOT_LOAD_EN is defined):
//   - After reset, words from a streaming loader are written into instruction
//     memory through its shared write port.
//   - The controller takes one word every two cycles: LOAD accepts a word and
//     WR writes it.
//   - Loading ends on the word marked last, or when the memory is full. In
//     the memory-full case the sticky load_overflow flag is raised.
//
// Run phase:
//   - The controller drives pc through sequential advance, stalls, branch
//     redirects and halt.
//   - HALT is left only through reset.
//
// When FETCH_CTRL_BOOT_LOAD_EN is not defined:
//   - Reset enters RUN at RESET_PC.
//   - load_ready, write_en, load_overflow and wdata are tied to 0.
//   - The loader inputs are unused.
//
// Ports:
//   clock, reset     rising-edge clock; synchronous active-high reset
//   load_valid       loader word available
//   load_data        loader word
//   load_last        marks the final loader word
//   load_ready       a loader word is accepted this cycle (decoded from state)
//   pc               instruction memory address: read in RUN, write in WR
//   wdata            instruction memory write data
//   write_en         instruction memory write strobe (high only in WR)
//   fetch_valid      instruction at pc is valid for decode (decoded from state)
//   stall            hold pc
//   redirect_valid   taken branch/jump
//   redirect_pc      redirect target; bits [1:0] are cleared
//   halt_req         stop fetching
//   load_overflow    sticky; the loader offered more than MEM_WORDS words
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] RESET_PC  = '0,
  parameter int              MEM_WORDS = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [ILEN-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic [ILEN-1:0] pc,
  output logic [ILEN-1:0] wdata,
  output logic            write_en,
  output logic            fetch_valid,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            load_overflow
);

  // XLEN is carried for consistency with the rest of the datapath only.
  localparam int unused_xlen = XLEN;

  localparam logic [ILEN-1:0] PC_STEP   = ILEN'(4);
  localparam logic [ILEN-1:0] MEM_BYTES = ILEN'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WR,
    S_RUN,
    S_HALT
  } state_t;

`ifdef FETCH_CTRL_BOOT_LOAD_EN
  localparam state_t RESET_STATE = S_LOAD;
`else
  localparam state_t RESET_STATE = S_RUN;
`endif

  state_t          state;
  state_t          state_next;
  logic [ILEN-1:0] pc_next;
  logic [ILEN-1:0] pc_inc;
  logic [ILEN-1:0] redirect_aligned;

  // The increment wraps modulo 2^ILEN. No flag is raised on wrap.
  assign pc_inc           = pc + PC_STEP;
  assign redirect_aligned = redirect_pc & ~ILEN'(3);

`ifdef FETCH_CTRL_BOOT_LOAD_EN
  logic [ILEN-1:0] wdata_next;
  logic            last_q;
  logic            last_next;
  logic            overflow_next;
`endif

  // Next-state and next-pc logic.
  always_comb begin
    // NOTE: every variable assigned here gets a default first. Without a
    // default, a path through the case that skips an assignment would infer
    // a latch.
    state_next = state;
    pc_next    = pc;
`ifdef FETCH_CTRL_BOOT_LOAD_EN
    wdata_next    = wdata;
    last_next     = last_q;
    overflow_next = load_overflow;
`endif
    case (state)
`ifdef FETCH_CTRL_BOOT_LOAD_EN
      S_LOAD: begin
        // load_ready is 1 in this state, so load_valid alone is the handshake.
        if (load_valid) begin
          wdata_next = load_data;
          last_next  = load_last;
          state_next = S_WR;
        end
      end
      S_WR: begin
        // The last-word marker takes priority over the memory-full condition.
        if (last_q) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
        end else if ((pc_inc - RESET_PC) == MEM_BYTES) begin
          overflow_next = 1'b1;
          state_next    = S_RUN;
          pc_next       = RESET_PC;
        end else begin
          state_next = S_LOAD;
          pc_next    = pc_inc;
        end
      end
`endif
      S_RUN: begin
        if (halt_req) begin
          state_next = S_HALT;
        end else if (redirect_valid) begin
          // A redirect wins over stall.
          pc_next = redirect_aligned;
        end else if (!stall) begin
          pc_next = pc_inc;
        end
      end
      default: begin
        // S_HALT: hold everything until reset.
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET_STATE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  assign fetch_valid = (state == S_RUN);

`ifdef FETCH_CTRL_BOOT_LOAD_EN
  // write_en is registered alongside pc and wdata, so the address, the data
  // and the strobe all change on the same edge and stay stable through WR.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdata         <= '0;
      write_en      <= 1'b0;
      last_q        <= 1'b0;
      load_overflow <= 1'b0;
    end else begin
      wdata         <= wdata_next;
      write_en      <= (state_next == S_WR);
      last_q        <= last_next;
      load_overflow <= overflow_next;
    end
  end

  assign load_ready = (state == S_LOAD);
`else
  logic unused_loader;
  assign unused_loader = ^{load_valid, load_data, load_last};

  assign load_ready    = 1'b0;
  assign wdata         = '0;
  assign write_en      = 1'b0;
  assign load_overflow = 1'b0;
`endif

endmodule
